div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Complements the single-cycle combinational ALU: it performs the inverse of multiply over many cycles, behind a valid/ready request/response handshake.
- Sits in the execute stage beside the ALU. The core stalls on req_ready/resp_valid.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be a power of two and at least 4.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  abort any in-flight operation (pipeline kill)
- req_valid  input  1  request strobe
- req_ready  output  1  unit can accept a request
- req_op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU (funct3[1:0])
- req_din1  input  WIDTH  dividend
- req_din2  input  WIDTH  divisor
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- resp_dout  output  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU)

Behaviour:
- Reset: only clk and rst; rst is synchronous, active-high. On the rst edge: state=IDLE, req_ready=1, resp_valid=0, resp_dout=0, internal registers cleared.
- States: IDLE, BUSY, FIX, DONE.
- req_ready=1 only in IDLE. resp_valid=1 only in DONE.
- Accept: a request is accepted on an edge with req_valid & req_ready. On that edge, latch op, the sign flags and operand magnitudes.
  - Signed ops (DIV, REM) take absolute values of the operands.
  - Unsigned ops use the raw operands.
- Special cases are decided on the accept edge and go IDLE->DONE directly; resp_valid is high the next cycle.
  - din2==0: DIV/DIVU give all ones; REM/REMU give din1.
  - Signed overflow (din1 = 0x8000_0000, din2 = 0xFFFF_FFFF, op DIV/REM): DIV gives 0x8000_0000; REM gives 0.
- Normal path:
  - IDLE->BUSY. BUSY performs one restoring iteration per edge for WIDTH edges.
  - Each iteration shifts the remainder left by 1 and brings in the next dividend MSB.
  - If remainder >= divisor magnitude: subtract the divisor and set quotient bit = 1; otherwise quotient bit = 0.
  - The iteration counter is $clog2(WIDTH)+1 bits and holds no wrap state. After the WIDTH-th iteration edge, go to FIX.
- FIX (one edge):
  - Negate the quotient if sign(din1) xor sign(din2) for DIV.
  - Negate the remainder if sign(din1) for REM.
  - Register resp_dout and go to DONE.
- Latency from accept edge to resp_valid high: WIDTH+2 cycles (34 for WIDTH=32). Special cases: 1 cycle.
- DONE:
  - resp_dout is held stable while resp_valid=1 and resp_ready=0.
  - On an edge with resp_ready=1: DONE->IDLE, resp_valid drops and req_ready rises the next cycle.
  - No back-to-back accept in the same cycle as response handshake.
- flush: any state goes to IDLE on the next edge; resp_valid=0 and no response is produced. A flush while in DONE discards the result. A flush in IDLE is a no-op. flush overrides a simultaneous req_valid (the request is not accepted).
- rst has priority over flush and all handshakes, including mid-operation: it returns to the reset values.
- Arithmetic is on unsigned WIDTH-bit magnitudes with a WIDTH+1-bit trial subtract. Result negation is two's complement modulo 2^WIDTH.
- Inputs are sampled only on the accept edge. Changes on req_din1/req_din2/req_op while BUSY have no effect.

Test Plan:
- DIVU 100 / 7 -> resp_dout=14, resp_valid exactly 34 cycles after the accept edge; REMU 100 / 7 -> 2.
- DIV -7 / 2 -> 0xFFFF_FFFD (-3); REM -7 / 2 -> 0xFFFF_FFFF (-1); REM 7 / -2 -> 1 (remainder takes the dividend's sign).
- Divide by zero: DIV 5 / 0 -> 0xFFFF_FFFF and REMU 5 / 0 -> 5. Overflow: DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000, REM -> 0. All three respond 1 cycle after accept.
- Backpressure: hold resp_ready=0 for 10 cycles in DONE -> resp_valid and resp_dout stay stable and req_ready=0. Raise resp_ready -> IDLE with req_ready=1 the next cycle.
- Flush at iteration 15 of DIVU 0xFFFF_FFFF / 3 -> IDLE next cycle with no resp_valid. A following DIVU 9 / 3 -> 3 with full latency.
- Assert rst during BUSY and during DONE -> all outputs at reset values the next cycle. A random 2000-op signed/unsigned sweep against the reference model matches.

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Valid/ready request and response handshakes; divide-by-zero and signed overflow resolve on accept.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_din1,
  input  logic [WIDTH-1:0] req_din2,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_dout
);

  // state | meaning
  // IDLE  | waiting for a request, req_ready=1
  // BUSY  | one restoring iteration per edge, WIDTH edges
  // FIX   | apply result sign, register resp_dout
  // DONE  | result held until resp_ready

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic             is_rem_q, neg_res_q;
  logic [WIDTH-1:0] resp_dout_q;

  logic             accept, signed_op, is_rem, a_neg, b_neg;
  logic             div_zero, ovf, special;
  logic [WIDTH-1:0] a_mag, b_mag, special_res, fix_val;
  logic [WIDTH:0]   shifted, trial;
  logic             ge;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign resp_dout  = resp_dout_q;

  assign accept    = req_valid & req_ready & ~flush;
  assign signed_op = ~req_op[0];
  assign is_rem    = req_op[1];
  assign a_neg     = signed_op & req_din1[WIDTH-1];
  assign b_neg     = signed_op & req_din2[WIDTH-1];
  assign a_mag     = a_neg ? -req_din1 : req_din1;
  assign b_mag     = b_neg ? -req_din2 : req_din2;
  assign div_zero  = (req_din2 == '0);
  assign ovf       = signed_op & (req_din1 == {1'b1, {(WIDTH-1){1'b0}}}) & (req_din2 == '1);
  assign special   = div_zero | ovf;

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = is_rem ? req_din1 : '1;
    else if (ovf)
      special_res = is_rem ? '0 : req_din1;
  end

  // Remainder always stays below the divisor, so the trial result fits WIDTH bits when taken.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, dvs_q});
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    fix_val = is_rem_q ? rem_q : quo_q;
    if (neg_res_q)
      fix_val = -fix_val;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = special ? DONE : BUSY;
      BUSY: if (cnt_q == CW'(1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush)
      state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      is_rem_q    <= 1'b0;
      neg_res_q   <= 1'b0;
      resp_dout_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            is_rem_q  <= is_rem;
            neg_res_q <= is_rem ? a_neg : (a_neg ^ b_neg);
            quo_q     <= a_mag;
            dvs_q     <= b_mag;
            rem_q     <= '0;
            cnt_q     <= CW'(WIDTH);
            if (special)
              resp_dout_q <= special_res;
          end
        end
        BUSY: begin
          rem_q <= ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], ge};
          cnt_q <= cnt_q - CW'(1);
        end
        FIX: resp_dout_q <= fix_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed and reference-model checks of div_unit: results, latency, backpressure, flush, reset.
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst, flush, req_valid, resp_ready;
  logic        req_ready, resp_valid;
  logic [1:0]  req_op;
  logic [31:0] req_din1, req_din2, resp_dout;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_din1(req_din1), .req_din2(req_din2),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_dout(resp_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
      return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return op[1] ? a % b : a / b;
  endfunction

  // Issue a request, wait for the response, complete the handshake.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    req_valid = 1'b1; req_op = op; req_din1 = a; req_din2 = b;
    step();
    req_valid = 1'b0; req_op = 2'($urandom); req_din1 = $urandom; req_din2 = $urandom;
    lat = 1;
    while (!resp_valid && lat < 100) begin
      step();
      lat++;
    end
    chk({tag, " valid"}, 32'(resp_valid), 32'd1);
    chk({tag, " result"}, resp_dout, exp);
    if (exp_lat > 0) chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk({tag, " ready after"}, {30'd0, req_ready, resp_valid}, 32'b10);
  endtask

  initial begin
    logic [31:0] a, b, held;
    logic [1:0]  op;

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = 2'b00; req_din1 = '0; req_din2 = '0;
    step(); step();
    rst = 1'b0;
    chk("reset outputs", {req_ready, resp_valid, 30'd0}, {1'b1, 1'b0, 30'd0});
    chk("reset dout", resp_dout, 32'd0);

    run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
    run_op("remu 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, 34);
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("rem 7/-2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
    run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    run_op("divu big", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
    run_op("div 5/0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu 5/0", OP_REMU, 32'd5, 32'd0, 32'd5, 1);
    run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("divu no ovf", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);

    // Backpressure: hold the response for 10 cycles.
    req_valid = 1'b1; req_op = OP_DIVU; req_din1 = 32'd100; req_din2 = 32'd7;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 40 && !resp_valid; i++) step();
    for (int i = 0; i < 10; i++) begin
      chk("bp hold flags", {30'd0, req_ready, resp_valid}, 32'b01);
      chk("bp hold dout", resp_dout, 32'd14);
      step();
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("bp release", {30'd0, req_ready, resp_valid}, 32'b10);

    // Flush on iteration 15.
    req_valid = 1'b1; req_op = OP_DIVU; req_din1 = 32'hFFFF_FFFF; req_din2 = 32'd3;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 14; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush busy", {30'd0, req_ready, resp_valid}, 32'b10);
    for (int i = 0; i < 40; i++) begin
      if (resp_valid) break;
      step();
    end
    chk("flush no resp", 32'(resp_valid), 32'd0);
    run_op("divu 9/3", OP_DIVU, 32'd9, 32'd3, 32'd3, 34);

    // Flush in DONE discards result; flush beats a simultaneous request.
    req_valid = 1'b1; req_op = OP_DIV; req_din1 = 32'd5; req_din2 = 32'd0;
    step();
    req_valid = 1'b0;
    chk("flush done pre", 32'(resp_valid), 32'd1);
    flush = 1'b1;
    step();
    chk("flush done", {30'd0, req_ready, resp_valid}, 32'b10);
    req_valid = 1'b1; req_op = OP_DIV; req_din1 = 32'd5; req_din2 = 32'd0;
    step();
    flush = 1'b0; req_valid = 1'b0;
    chk("flush beats req", {30'd0, req_ready, resp_valid}, 32'b10);
    step();
    chk("flush beats req later", 32'(resp_valid), 32'd0);

    // Reset mid-operation and in DONE.
    req_valid = 1'b1; req_op = OP_DIVU; req_din1 = 32'd100; req_din2 = 32'd7;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst busy", {req_ready, resp_valid, 30'd0}, {1'b1, 1'b0, 30'd0});
    chk("rst busy dout", resp_dout, 32'd0);
    req_valid = 1'b1; req_op = OP_REMU; req_din1 = 32'd5; req_din2 = 32'd0;
    step();
    req_valid = 1'b0;
    held = resp_dout;
    chk("rst done pre", held, 32'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst done", {req_ready, resp_valid, 30'd0}, {1'b1, 1'b0, 30'd0});
    chk("rst done dout", resp_dout, 32'd0);
    run_op("after rst", OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34);

    // Random sweep against the reference model, with biased edge operands.
    for (int i = 0; i < 2000; i++) begin
      op = 2'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        4: a = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      run_op("sweep", op, a, b, ref_div(op, a, b), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
